// File: rtl/atomrvcore_ifu_pf.sv
// Prefetching instruction fetch unit for atomRVCORE.
// Issues word fetches over a request/grant port, buffers returned
// instructions with their PCs in a DEPTH-entry FIFO, and presents the head
// to the decoder over valid/ready. A redirect flushes the FIFO, retargets the
// fetch path and marks every in-flight response as stale.
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   fetch_en_i                 allow new fetch requests
//   imem_req_o/addr_o/gnt_i    fetch request channel
//   imem_rvalid_i/rdata_i      in-order response channel
//   redirect_i/redirect_pc_i   control-flow redirect pulse and target
//   instr_valid_o/ready_i      decoder handshake, instr_o/instr_pc_o payload
//   spurious_o                 response seen with nothing outstanding
module atomrvcore_ifu_pf #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fetch_en_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] instr_pc_o,
  output logic                 spurious_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);  // counters 0..DEPTH
  localparam int unsigned PW = $clog2(DEPTH);      // FIFO pointers
  localparam int unsigned SW = CW + 1;             // credit sum
  localparam logic [DATAWIDTH-1:0] PC_STEP  = DATAWIDTH'(4);
  localparam logic [DATAWIDTH-1:0] PC_ALIGN = ~DATAWIDTH'(3);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATAWIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        discard_q, discard_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [DATAWIDTH-1:0] pc_mem_q [DEPTH];
  logic [DATAWIDTH-1:0] pc_mem_d [DEPTH];
  logic [DATAWIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATAWIDTH-1:0] instr_mem_d [DEPTH];

  logic                 gnt_fire;
  logic                 rsp_fire;
  logic                 push;
  logic                 pop;
  logic [DATAWIDTH-1:0] redirect_tgt;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en_i)  state_d = FETCH;
      FETCH:   if (!fetch_en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: request only while buffered plus in-flight words leave room
  always_comb begin
    imem_req_o = 1'b0;
    if ((state_q == FETCH) && ((SW'(count_q) + SW'(outstanding_q)) < SW'(DEPTH)))
      imem_req_o = 1'b1;
  end

  assign gnt_fire     = imem_req_o && imem_gnt_i;
  assign rsp_fire     = imem_rvalid_i && (outstanding_q != '0);
  assign push         = rsp_fire && (discard_q == '0) && !redirect_i;
  assign pop          = instr_valid_o && instr_ready_i && !redirect_i;
  assign redirect_tgt = redirect_pc_i & PC_ALIGN;

  // Fetch/response bookkeeping and FIFO update
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;
    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (gnt_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);

    if (push) begin
      pc_mem_d[wr_ptr_q]    = resp_pc_q;
      instr_mem_d[wr_ptr_q] = imem_rdata_i;
      wr_ptr_d              = wr_ptr_q + PW'(1);
      resp_pc_d             = resp_pc_q + PC_STEP;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // Everything still in flight after this cycle, including a grant taken
    // now on the old path, belongs to the abandoned stream.
    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      discard_d  = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pc_mem_q      <= '{default: '0};
      instr_mem_q   <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pc_mem_q      <= pc_mem_d;
      instr_mem_q   <= instr_mem_d;
    end
  end

  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];
  assign spurious_o    = imem_rvalid_i && (outstanding_q == '0);

endmodule

// File: tb/tb_atomrvcore_ifu_pf.sv
// Testbench for atomrvcore_ifu_pf: an in-order variable-latency memory
// model plus a stream reference (delivered PCs are contiguous from the last
// redirect target, each carrying the memory word at that PC).
module tb_atomrvcore_ifu_pf;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        spurious_o;

  atomrvcore_ifu_pf #(.DATAWIDTH(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_en_i(fetch_en_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } resp_t;
  resp_t       mq[$];
  logic [31:0] dlv[$];

  int total = 0, bad = 0;
  int cyc = 0, last_due = 0, n_deliv = 0, n_grant = 0, first_valid_cyc = -1;
  logic [31:0] exp_fetch = RST_PC, exp_pc = RST_PC;

  bit fen, rdy, redir, force_spur, rnd_ready;
  logic [31:0] rpc;
  int gnt_mode, lat_lo, lat_hi;

  bit ev_grant, ev_rvalid, ev_pop, last_req;
  bit prev_valid, prev_pop, prev_redir;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic set_idle_cfg();
    fen = 0; rdy = 0; redir = 0; rpc = '0; force_spur = 0; rnd_ready = 0;
    gnt_mode = 0; lat_lo = 1; lat_hi = 1;
  endtask

  // One clock cycle: drive at negedge, observe 1ns later, update the model.
  task automatic tick();
    resp_t r;
    int    lat;
    bit    exp_spur;
    @(negedge clk);
    fetch_en_i    = fen;
    instr_ready_i = rnd_ready ? 1'($urandom % 2) : rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    case (gnt_mode)
      1:       imem_gnt_i = 1'b1;
      2:       imem_gnt_i = 1'($urandom % 2);
      default: imem_gnt_i = 1'b0;
    endcase
    exp_spur = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rvalid_i = 1'b1; imem_rdata_i = r.data;
    end else if (force_spur) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; exp_spur = 1'b1;
    end else begin
      imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
    end
    #1;
    total++;
    if (spurious_o !== exp_spur) begin
      bad++; $display("FAIL spurious cyc=%0d got=%b want=%b", cyc, spurious_o, exp_spur);
    end
    total++;
    if (imem_addr_o !== exp_fetch) begin
      bad++; $display("FAIL fetch_addr cyc=%0d got=%h want=%h", cyc, imem_addr_o, exp_fetch);
    end
    if (prev_redir) begin
      total++;
      if (instr_valid_o !== 1'b0) begin
        bad++; $display("FAIL valid_after_redirect cyc=%0d got=%b want=0", cyc, instr_valid_o);
      end
    end
    if (prev_valid && !prev_pop && !prev_redir) begin
      total++;
      if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, prev_pc, prev_instr}) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got=%b/%h/%h want=1/%h/%h", cyc,
                 instr_valid_o, instr_pc_o, instr_o, prev_pc, prev_instr);
      end
    end
    if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    ev_grant  = imem_req_o && imem_gnt_i;
    ev_rvalid = imem_rvalid_i;
    ev_pop    = instr_valid_o && instr_ready_i;
    last_req  = imem_req_o;
    if (ev_grant) begin
      n_grant++;
      lat = $urandom_range(lat_hi, lat_lo);
      r.due = cyc + lat;
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.data = memword(imem_addr_o);
      mq.push_back(r);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (ev_pop && !redirect_i) begin
      total++;
      if (instr_pc_o !== exp_pc) begin
        bad++; $display("FAIL instr_pc cyc=%0d got=%h want=%h", cyc, instr_pc_o, exp_pc);
      end
      total++;
      if (instr_o !== memword(exp_pc)) begin
        bad++; $display("FAIL instr_data cyc=%0d got=%h want=%h", cyc, instr_o, memword(exp_pc));
      end
      dlv.push_back(instr_pc_o);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (redirect_i) begin
      exp_fetch = redirect_pc_i & ~32'h3;
      exp_pc    = redirect_pc_i & ~32'h3;
    end
    prev_valid = instr_valid_o; prev_pop = ev_pop; prev_redir = redirect_i;
    prev_pc = instr_pc_o; prev_instr = instr_o;
    @(posedge clk);
    cyc++;
  endtask

  // Reset for one edge and check every output against its reset value.
  task automatic test_reset();
    @(negedge clk);
    rst_ni = 1'b0; fetch_en_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    imem_rdata_i = '0; redirect_i = 0; redirect_pc_i = '0; instr_ready_i = 0;
    @(posedge clk); #1;
    total++;
    if ({imem_req_o, instr_valid_o, spurious_o} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", imem_req_o, instr_valid_o, spurious_o);
    end
    total++;
    if (imem_addr_o !== RST_PC) begin
      bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr_o, RST_PC);
    end
    total++;
    if ({instr_o, instr_pc_o} !== 64'h0) begin
      bad++; $display("FAIL reset_instr got=%h/%h want=0/0", instr_o, instr_pc_o);
    end
    mq.delete(); dlv.delete();
    exp_fetch = RST_PC; exp_pc = RST_PC;
    prev_valid = 0; prev_pop = 0; prev_redir = 0;
    n_deliv = 0; n_grant = 0; first_valid_cyc = -1;
    set_idle_cfg();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_linear();
    int t0;
    test_reset();
    fen = 1; rdy = 1; gnt_mode = 1;
    t0 = cyc;
    repeat (20) tick();
    total++;
    if (first_valid_cyc - t0 !== 3) begin
      bad++; $display("FAIL first_valid_latency got=%0d want=3", first_valid_cyc - t0);
    end
    total++;
    if (n_deliv !== 17) begin
      bad++; $display("FAIL linear_throughput got=%0d want=17", n_deliv);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    fen = 1; rdy = 0; gnt_mode = 1;
    repeat (10) tick();
    total++;
    if (n_grant !== 4) begin
      bad++; $display("FAIL bp_grants got=%0d want=4", n_grant);
    end
    total++;
    if (last_req !== 1'b0) begin
      bad++; $display("FAIL bp_req_low got=%b want=0", last_req);
    end
    rdy = 1; n_deliv = 0;
    repeat (15) tick();
    total++;
    if (n_deliv < 8) begin
      bad++; $display("FAIL bp_resume got=%0d want>=8", n_deliv);
    end
  endtask

  task automatic test_redirect_inflight();
    int guard;
    test_reset();
    fen = 1; rdy = 1; gnt_mode = 1; lat_lo = 3; lat_hi = 3;
    guard = 0;
    while (mq.size() != 2 && guard < 20) begin tick(); guard++; end
    total++;
    if (mq.size() != 2) begin
      bad++; $display("FAIL inflight_setup got=%0d want=2", mq.size());
    end
    gnt_mode = 0; redir = 1; rpc = 32'h0000_0100;
    tick();
    redir = 0; gnt_mode = 1; dlv.delete();
    repeat (25) tick();
    total++;
    if (dlv.size() < 1 || dlv[0] !== 32'h0000_0100) begin
      bad++; $display("FAIL inflight_target got=%h want=%h", (dlv.size() > 0) ? dlv[0] : 32'hx, 32'h100);
    end
  endtask

  task automatic test_simultaneous();
    test_reset();
    fen = 1; rdy = 1; gnt_mode = 1;
    repeat (6) tick();
    redir = 1; rpc = 32'h0000_0240;
    tick();
    total++;
    if ({ev_grant, ev_rvalid, ev_pop} !== 3'b111) begin
      bad++; $display("FAIL simul_events got=%b%b%b want=111", ev_grant, ev_rvalid, ev_pop);
    end
    redir = 0; dlv.delete();
    repeat (12) tick();
    total++;
    if (dlv.size() < 1 || dlv[0] !== 32'h0000_0240) begin
      bad++; $display("FAIL simul_target got=%h want=%h", (dlv.size() > 0) ? dlv[0] : 32'hx, 32'h240);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    fen = 1; rdy = 1; gnt_mode = 1;
    repeat (4) tick();
    redir = 1; rpc = 32'hFFFF_FFFE;
    tick();
    redir = 0; dlv.delete();
    repeat (10) tick();
    total++;
    if (dlv.size() < 2 || dlv[0] !== 32'hFFFF_FFFC || dlv[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_seq got=%h,%h want=fffffffc,00000000",
               (dlv.size() > 0) ? dlv[0] : 32'hx, (dlv.size() > 1) ? dlv[1] : 32'hx);
    end
  endtask

  task automatic test_spurious_and_reset();
    test_reset();
    fen = 1; rdy = 0; gnt_mode = 1;
    repeat (8) tick();
    force_spur = 1;
    tick();
    force_spur = 0;
    tick();
    rdy = 1; dlv.delete();
    repeat (10) tick();
    total++;
    if (dlv.size() < 4 || dlv[0] !== RST_PC || dlv[3] !== RST_PC + 32'd12) begin
      bad++; $display("FAIL spurious_fifo got=%0d entries want>=4 from %h", dlv.size(), RST_PC);
    end
    // reset in the middle of a running stream
    repeat (3) tick();
    test_reset();
    fen = 1; rdy = 1; gnt_mode = 1;
    repeat (12) tick();
    total++;
    if (dlv.size() < 1 || dlv[0] !== RST_PC) begin
      bad++; $display("FAIL restart_pc got=%h want=%h", (dlv.size() > 0) ? dlv[0] : 32'hx, RST_PC);
    end
  endtask

  task automatic test_random();
    test_reset();
    rnd_ready = 1; gnt_mode = 2; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      fen   = ($urandom % 8) != 0;
      redir = ($urandom % 25) == 0;
      rpc   = $urandom;
      tick();
    end
    total++;
    if (n_deliv < 40) begin
      bad++; $display("FAIL random_progress got=%0d want>=40", n_deliv);
    end
  endtask

  initial begin
    set_idle_cfg();
    test_linear();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_wrap();
    test_spurious_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atomrvcore_ifu_pf.md
# atomrvcore_ifu_pf

Prefetching instruction fetch unit for the atomRVCORE pipeline. It replaces the single-cycle PC-to-ICCM fetch path: it issues word fetches through a request/grant port, holds returned instructions with their PCs in a DEPTH-entry FIFO, and hands them to the decoder over a valid/ready handshake. Control-flow redirects from branch, JAL or JALR flush the FIFO and discard in-flight responses. Memories of variable latency are supported.

## Interface
- DATAWIDTH, 32, instruction and PC width
- DEPTH, 4, FIFO entries and maximum credits; a power of two and at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous and active-low
- fetch_en_i  in  1  fetch enable; when low, no new requests are issued
- imem_req_o  out  1  fetch request
- imem_addr_o  out  DATAWIDTH  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in order
- imem_rdata_i  in  DATAWIDTH  response instruction word
- redirect_i  in  1  one-cycle pulse that flushes the FIFO and changes the fetch path
- redirect_pc_i  in  DATAWIDTH  redirect target; bits [1:0] are ignored and treated as 0
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  decoder accepts the head
- instr_o  out  DATAWIDTH  head instruction
- instr_pc_o  out  DATAWIDTH  head PC
- spurious_o  out  1  one-cycle pulse when imem_rvalid_i arrives with no request outstanding

## Operation
- FSM states:
  - IDLE: reset state.
  - FETCH: entered from IDLE when fetch_en_i=1; returns to IDLE when fetch_en_i=0.
  - Outstanding responses still complete while in IDLE.
- Registers:
  - fetch_pc: next request address.
  - resp_pc: PC of the next non-discarded response.
  - outstanding: 0..DEPTH, counts granted but not yet returned requests.
  - discard: 0..DEPTH, counts stale responses still to drop.
  - FIFO of {pc, instr} with occupancy count.
- Request generation:
  - imem_req_o = (state==FETCH) && (count + outstanding < DEPTH).
  - imem_req_o is not gated by redirect_i; there is no combinational path from redirect_i.
  - imem_addr_o = fetch_pc.
  - A request is accepted when imem_req_o && imem_gnt_i. On acceptance, fetch_pc += 4 and outstanding += 1.
  - The address is held stable while a request is pending and ungranted.
- Response handling:
  - On rvalid with outstanding>0, outstanding -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise {resp_pc, rdata} is pushed and resp_pc += 4.
  - The credit rule guarantees no overflow.
- Pop: on instr_valid_o && instr_ready_i the head is removed.
- Redirect (redirect_i=1):
  - fetch_pc and resp_pc take {redirect_pc_i[31:2],2'b00}.
  - The FIFO is emptied.
  - discard takes the outstanding value after this cycle's gnt/rvalid updates (minus any existing discard already consumed this cycle).
  - A grant in the redirect cycle is for the old path and is therefore counted as stale.
  - An rvalid in the redirect cycle is dropped.
  - A pop in the redirect cycle has no effect beyond the flush.
- Simultaneous push and pop: count is unchanged. A push into an empty FIFO becomes visible the next cycle; there is no bypass.
- Spurious response (rvalid with outstanding==0): the response is ignored, counters are unchanged, and spurious_o=1 for that cycle.
- PC arithmetic is modulo 2^DATAWIDTH; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, spurious_o=0.
  - state=IDLE; all counters 0; fetch_pc=resp_pc=RESET_PC.
- Reset asserted mid-operation clears all state on the next edge. Responses to requests issued before reset are the memory's responsibility; after reset they are flagged as spurious.
- The earliest imem_req_o after reset release is the cycle after fetch_en_i is first sampled high.
- Minimum latency:
  - grant in cycle N;
  - rvalid in cycle N+1;
  - instr_valid_o in cycle N+2.
- Redirect in cycle R:
  - imem_addr_o = target in cycle R+1;
  - instr_valid_o=0 in cycle R+1.
- With a zero-wait memory and instr_ready_i=1 held high, throughput is one instruction per cycle once the pipeline fills.
- Backpressure: while instr_ready_i=0, instr_o and instr_pc_o are held stable. Fetch continues until count + outstanding == DEPTH.

## Test plan
- Reset and linear fetch:
  - Stimulus: RESET_PC=0, fetch_en_i=1, always-grant memory with 1-cycle rvalid, ready=1.
  - Required response: instr_pc_o sequence 0,4,8,C… back-to-back; first valid 3 cycles after fetch_en_i.
- Backpressure:
  - Stimulus: DEPTH=4, ready=0 for 10 cycles.
  - Required response: exactly 4 grants; imem_req_o low afterwards; no loss or duplication when ready returns.
- Redirect with in-flight data:
  - Stimulus: memory latency 3; redirect to 32'h100 while 2 requests are outstanding.
  - Required response: both stale responses dropped; next delivered instr_pc_o=32'h100.
- Simultaneous events in one cycle:
  - Stimulus: redirect, grant, rvalid and pop all in the same cycle.
  - Required response: FIFO empty; the granted request is later discarded; next delivered PC = target.
- Misaligned target and wrap-around:
  - Stimulus: redirect_pc_i=32'hFFFF_FFFE.
  - Required response: instr_pc_o sequence FFFF_FFFC, 0000_0000.
- Spurious response and reset:
  - Stimulus: rvalid with nothing outstanding.
  - Required response: spurious_o pulses and the FIFO is unchanged.
  - Stimulus: rst_ni low for 1 cycle mid-stream.
  - Required response: all outputs at their reset values on the next cycle.
